// File: rtl/load_value_predictor.sv
// ---------------------------------------------------------------------------------------------
// load_value_predictor
//
// Last-value load predictor. On a D-cache load miss it looks up a direct-mapped table indexed
// by pc[IDX_BITS+1:2]. If the entry hits with enough confidence, it issues a speculative value
// and holds vp_lock until the real value arrives. It then pulses done (correct guess) or
// recover (wrong guess). After recover it waits for the register snapshot restore. Every
// resolved load trains the table.
//
// Optional feature: define VP_STATS_EN to build the saturating statistics counters.
// Without it the stat_* ports are tied to zero.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_start, i_start_pc load miss detected / its PC (accepted only while o_start_ready)
//   o_start_ready       high only in IDLE (and out of reset)
//   i_resolve_valid     true load value returned by the D-cache
//   i_resolve_data      true load value
//   i_recovery_done     register snapshot restore complete
//   o_pred_valid        o_pred_data is a live prediction
//   o_pred_data         predicted load value (0 when no prediction is live)
//   o_vp_lock           speculation in flight (SPEC and RECOVER)
//   o_done              1-cycle pulse: prediction verified correct
//   o_recover           1-cycle pulse: misprediction, restore snapshot
//   o_last_pc           PC of the most recently accepted start
//   o_stat_pred/hit/mispred  prediction statistics
// ---------------------------------------------------------------------------------------------
module load_value_predictor #(
    parameter int unsigned IDX_BITS  = 6,
    parameter int unsigned CONF_BITS = 2,
    parameter int unsigned CONF_TH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_start_pc,
    output logic        o_start_ready,
    input  logic        i_resolve_valid,
    input  logic [31:0] i_resolve_data,
    input  logic        i_recovery_done,
    output logic        o_pred_valid,
    output logic [31:0] o_pred_data,
    output logic        o_vp_lock,
    output logic        o_done,
    output logic        o_recover,
    output logic [31:0] o_last_pc,
    output logic [31:0] o_stat_pred,
    output logic [31:0] o_stat_hit,
    output logic [31:0] o_stat_mispred
);

    localparam int unsigned DEPTH = 1 << IDX_BITS;
    localparam int unsigned TAG_W = 30 - IDX_BITS;

    localparam logic [CONF_BITS-1:0] CONF_MAX  = '1;
    localparam logic [CONF_BITS-1:0] CONF_TH_V = CONF_BITS'(CONF_TH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_SPEC    = 3'd2;
    localparam logic [2:0] S_RECOVER = 3'd3;
    localparam logic [2:0] S_TRAIN   = 3'd4;

    // Control state
    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_cur_pc;
    logic [31:0] r_last_pc;
    logic [31:0] r_pred_data;
    logic        r_done;
    logic        r_recover;
    logic        r_rd_pend;

    // Prediction table
    logic                 r_valid [DEPTH];
    logic [TAG_W-1:0]     r_tag   [DEPTH];
    logic [31:0]          r_data  [DEPTH];
    logic [CONF_BITS-1:0] r_conf  [DEPTH];

    logic [IDX_BITS-1:0]  w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit;
    logic                 w_confident;
    logic                 w_match;
    logic                 w_train_en;
    logic [31:0]          w_data_nxt;
    logic [CONF_BITS-1:0] w_conf_nxt;
    logic                 w_spec_enter;
    logic                 w_done_nxt;
    logic                 w_recover_nxt;
    logic                 w_rec_exit;
    logic                 w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^r_cur_pc[1:0];

    // Only one load is in flight, so the entry for cur_pc is read combinationally in every
    // state. A write in the same cycle lands on the clock edge, so the read sees old data.
    assign w_idx       = r_cur_pc[IDX_BITS+1:2];
    assign w_tag       = r_cur_pc[31:IDX_BITS+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_confident = w_hit && (r_conf[w_idx] >= CONF_TH_V);
    assign w_match     = (r_data[w_idx] == i_resolve_data);

    assign w_train_en = i_resolve_valid &&
                        ((r_state == S_LOOKUP) || (r_state == S_SPEC) || (r_state == S_TRAIN));

    always_comb begin
        w_data_nxt = i_resolve_data;
        w_conf_nxt = '0;
        if (w_hit && w_match) begin
            w_data_nxt = r_data[w_idx];
            w_conf_nxt = (r_conf[w_idx] == CONF_MAX) ? CONF_MAX : r_conf[w_idx] + 1'b1;
        end
    end

    assign w_spec_enter  = (r_state == S_LOOKUP) && !i_resolve_valid && w_confident;
    assign w_done_nxt    = (r_state == S_SPEC) && i_resolve_valid &&
                           (i_resolve_data == r_pred_data);
    assign w_recover_nxt = (r_state == S_SPEC) && i_resolve_valid &&
                           (i_resolve_data != r_pred_data);
    // A restore ack seen during the recover pulse cycle is remembered and acted on next cycle.
    assign w_rec_exit    = (r_state == S_RECOVER) && !r_recover &&
                           (i_recovery_done || r_rd_pend);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (i_resolve_valid)  w_state_nxt = S_IDLE;
                else if (w_confident) w_state_nxt = S_SPEC;
                else                  w_state_nxt = S_TRAIN;
            end
            S_SPEC: begin
                if (w_done_nxt)         w_state_nxt = S_IDLE;
                else if (w_recover_nxt) w_state_nxt = S_RECOVER;
            end
            S_RECOVER: begin
                if (w_rec_exit) w_state_nxt = S_IDLE;
            end
            S_TRAIN: begin
                if (i_resolve_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cur_pc    <= '0;
            r_last_pc   <= '0;
            r_pred_data <= '0;
            r_done      <= 1'b0;
            r_recover   <= 1'b0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_recover <= w_recover_nxt;
            if ((r_state == S_IDLE) && i_start) begin
                r_cur_pc  <= i_start_pc;
                r_last_pc <= i_start_pc;
            end
            if (w_spec_enter) begin
                r_pred_data <= r_data[w_idx];
            end else if ((r_state == S_SPEC) && i_resolve_valid) begin
                r_pred_data <= '0;
            end
            if ((r_state == S_RECOVER) && r_recover && i_recovery_done) begin
                r_rd_pend <= 1'b1;
            end else if (w_rec_exit) begin
                r_rd_pend <= 1'b0;
            end
        end
    end

    // Valid and confidence are reset; tag and data are don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_valid[i] <= 1'b0;
                r_conf[i]  <= '0;
            end
        end else if (w_train_en) begin
            r_valid[w_idx] <= 1'b1;
            r_conf[w_idx]  <= w_conf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_train_en) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= w_data_nxt;
        end
    end

    // Outputs. start_ready is gated by rst_n so every output reads 0 while reset is held.
    assign o_start_ready = (r_state == S_IDLE) && rst_n;
    assign o_pred_valid  = (r_state == S_SPEC);
    assign o_pred_data   = (r_state == S_SPEC) ? r_pred_data : 32'd0;
    assign o_vp_lock     = (r_state == S_SPEC) || (r_state == S_RECOVER);
    assign o_done        = r_done;
    assign o_recover     = r_recover;
    assign o_last_pc     = r_last_pc;

`ifdef VP_STATS_EN
    logic [31:0] r_stat_pred;
    logic [31:0] r_stat_hit;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pred    <= '0;
            r_stat_hit     <= '0;
            r_stat_mispred <= '0;
        end else begin
            if (w_spec_enter && (r_stat_pred != 32'hFFFF_FFFF)) begin
                r_stat_pred <= r_stat_pred + 32'd1;
            end
            if (w_done_nxt && (r_stat_hit != 32'hFFFF_FFFF)) begin
                r_stat_hit <= r_stat_hit + 32'd1;
            end
            if (w_recover_nxt && (r_stat_mispred != 32'hFFFF_FFFF)) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign o_stat_pred    = r_stat_pred;
    assign o_stat_hit     = r_stat_hit;
    assign o_stat_mispred = r_stat_mispred;
`else
    assign o_stat_pred    = 32'd0;
    assign o_stat_hit     = 32'd0;
    assign o_stat_mispred = 32'd0;
`endif

endmodule

// File: tb/tb_load_value_predictor.sv
// Self-checking bench for load_value_predictor: directed vector table, hand sequences for
// start-while-busy and reset-in-RECOVER, then randomized transactions against a table model.
module tb_load_value_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [31:0] i_start_pc;
    logic        o_start_ready;
    logic        i_resolve_valid;
    logic [31:0] i_resolve_data;
    logic        i_recovery_done;
    logic        o_pred_valid;
    logic [31:0] o_pred_data;
    logic        o_vp_lock;
    logic        o_done;
    logic        o_recover;
    logic [31:0] o_last_pc;
    logic [31:0] o_stat_pred;
    logic [31:0] o_stat_hit;
    logic [31:0] o_stat_mispred;

    always #5 clk = ~clk;

    load_value_predictor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_start_pc      (i_start_pc),
        .o_start_ready   (o_start_ready),
        .i_resolve_valid (i_resolve_valid),
        .i_resolve_data  (i_resolve_data),
        .i_recovery_done (i_recovery_done),
        .o_pred_valid    (o_pred_valid),
        .o_pred_data     (o_pred_data),
        .o_vp_lock       (o_vp_lock),
        .o_done          (o_done),
        .o_recover       (o_recover),
        .o_last_pc       (o_last_pc),
        .o_stat_pred     (o_stat_pred),
        .o_stat_hit      (o_stat_hit),
        .o_stat_mispred  (o_stat_mispred)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: one record per table slot, conf as a plain integer.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_data  [64];
    int          m_conf  [64];
    int          exp_sp, exp_sh, exp_sm;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] val;
        bit          early;
        bit          exp_pv;
        logic [31:0] exp_pd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_conf[i]  = 0;
        end
        exp_sp = 0;
        exp_sh = 0;
        exp_sm = 0;
    endfunction

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == (pc / 256));
    endfunction

    function automatic void model_train(input logic [31:0] pc, input logic [31:0] val);
        int i;
        i = midx(pc);
        if (model_hit(pc) && m_data[i] == val) begin
            if (m_conf[i] < 3) m_conf[i] = m_conf[i] + 1;
        end else begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc / 256;
            m_data[i]  = val;
            m_conf[i]  = 0;
        end
    endfunction

    task automatic chk_all_zero(input string name);
        chk({name, "_ready"}, {31'd0, o_start_ready}, 32'd0);
        chk({name, "_pv"},    {31'd0, o_pred_valid},  32'd0);
        chk({name, "_pd"},    o_pred_data,            32'd0);
        chk({name, "_lock"},  {31'd0, o_vp_lock},     32'd0);
        chk({name, "_done"},  {31'd0, o_done},        32'd0);
        chk({name, "_rec"},   {31'd0, o_recover},     32'd0);
        chk({name, "_lpc"},   o_last_pc,              32'd0);
        chk({name, "_stp"},   o_stat_pred,            32'd0);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        i_start         = 1'b0;
        i_start_pc      = '0;
        i_resolve_valid = 1'b0;
        i_resolve_data  = '0;
        i_recovery_done = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, o_start_ready}, 32'd1);
    endtask

    // One load miss from IDLE to IDLE. Entered and left at a negedge in IDLE.
    task automatic txn(input logic [31:0] pc, input logic [31:0] val, input bit early,
                       input bit exp_pv, input logic [31:0] exp_pd, input int dly,
                       input int rdly, input string nm);
        bit exp_ok, exp_bad;
        chk({nm, "_ready0"}, {31'd0, o_start_ready}, 32'd1);
        i_start    = 1'b1;
        i_start_pc = pc;
        @(negedge clk);
        i_start = 1'b0;
        chk({nm, "_lpc"},    o_last_pc, pc);
        chk({nm, "_ready1"}, {31'd0, o_start_ready}, 32'd0);
        chk({nm, "_lk_pv"},  {31'd0, o_pred_valid}, 32'd0);
        if (early) begin
            i_resolve_valid = 1'b1;
            i_resolve_data  = val;
            @(negedge clk);
            i_resolve_valid = 1'b0;
            chk({nm, "_e_ready"}, {31'd0, o_start_ready}, 32'd1);
            chk({nm, "_e_lock"},  {31'd0, o_vp_lock | o_pred_valid}, 32'd0);
            chk({nm, "_e_pulse"}, {31'd0, o_done | o_recover}, 32'd0);
            model_train(pc, val);
            return;
        end
        @(negedge clk);
        for (int k = 0; k <= dly; k++) begin
            chk({nm, "_pv"},   {31'd0, o_pred_valid}, {31'd0, exp_pv});
            chk({nm, "_lock"}, {31'd0, o_vp_lock},    {31'd0, exp_pv});
            chk({nm, "_pd"},   o_pred_data,           exp_pv ? exp_pd : 32'd0);
            chk({nm, "_nopulse"}, {31'd0, o_done | o_recover}, 32'd0);
            if (k < dly) @(negedge clk);
        end
        if (exp_pv) exp_sp++;
        i_resolve_valid = 1'b1;
        i_resolve_data  = val;
        @(negedge clk);
        i_resolve_valid = 1'b0;
        exp_ok  = exp_pv && (val == exp_pd);
        exp_bad = exp_pv && (val != exp_pd);
        if (exp_ok)  exp_sh++;
        if (exp_bad) exp_sm++;
        model_train(pc, val);
        chk({nm, "_done"},  {31'd0, o_done},        {31'd0, exp_ok});
        chk({nm, "_rec"},   {31'd0, o_recover},     {31'd0, exp_bad});
        chk({nm, "_pv2"},   {31'd0, o_pred_valid},  32'd0);
        chk({nm, "_lock2"}, {31'd0, o_vp_lock},     {31'd0, exp_bad});
        if (!exp_bad) return;
        // Restore ack either during the recover pulse (must be deferred) or later.
        if (rdly == 0) i_recovery_done = 1'b1;
        @(negedge clk);
        i_recovery_done = 1'b0;
        chk({nm, "_rlock"}, {31'd0, o_vp_lock}, 32'd1);
        chk({nm, "_rpulse"}, {31'd0, o_done | o_recover}, 32'd0);
        if (rdly > 0) begin
            for (int k = 1; k < rdly; k++) begin
                @(negedge clk);
                chk({nm, "_rwait"}, {31'd0, o_vp_lock}, 32'd1);
            end
            i_recovery_done = 1'b1;
            @(negedge clk);
            i_recovery_done = 1'b0;
        end else begin
            @(negedge clk);
        end
        chk({nm, "_rexit"}, {31'd0, o_vp_lock}, 32'd0);
        chk({nm, "_rready"}, {31'd0, o_start_ready}, 32'd1);
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] val, input bit early,
                                input bit pv, input logic [31:0] pd);
        vec_t v;
        v.pc = pc; v.val = val; v.early = early; v.exp_pv = pv; v.exp_pd = pd;
        return v;
    endfunction

    task automatic chk_stats(input string nm);
`ifdef VP_STATS_EN
        chk({nm, "_stat_pred"},    o_stat_pred,    32'(exp_sp));
        chk({nm, "_stat_hit"},     o_stat_hit,     32'(exp_sh));
        chk({nm, "_stat_mispred"}, o_stat_mispred, 32'(exp_sm));
`else
        chk({nm, "_stat_pred"},    o_stat_pred,    32'd0);
        chk({nm, "_stat_hit"},     o_stat_hit,     32'd0);
        chk({nm, "_stat_mispred"}, o_stat_mispred, 32'd0);
`endif
    endtask

    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0080_0010;
    localparam logic [31:0] PC = 32'h0040_0020;

    initial begin
        logic [31:0] pcs [4];
        logic [31:0] pc, val;
        bit          pv;
        int          sp_before;

        // Directed vectors: training ramp, done, mispredict, aliasing alternation.
        vecs.push_back(mk(PA, 32'h1234, 1'b0, 1'b0, 32'h0));      // miss, allocate conf=0
        vecs.push_back(mk(PA, 32'h1234, 1'b0, 1'b0, 32'h0));      // conf 1
        vecs.push_back(mk(PA, 32'h1234, 1'b0, 1'b0, 32'h0));      // conf 2
        vecs.push_back(mk(PA, 32'h1234, 1'b0, 1'b1, 32'h1234));   // predict, done, conf 3
        vecs.push_back(mk(PA, 32'h5678, 1'b0, 1'b1, 32'h1234));   // recover, data 5678 conf 0
        vecs.push_back(mk(PA, 32'h5678, 1'b0, 1'b0, 32'h0));      // conf 1
        vecs.push_back(mk(PA, 32'h5678, 1'b1, 1'b0, 32'h0));      // resolve in LOOKUP, conf 2
        vecs.push_back(mk(PA, 32'h5678, 1'b1, 1'b0, 32'h0));      // confident but early: train
        vecs.push_back(mk(PA, 32'h5678, 1'b0, 1'b1, 32'h5678));   // conf 3 -> done
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(PB, 32'hAAAA, 1'b0, 1'b0, 32'h0));  // evicts PA
            vecs.push_back(mk(PA, 32'hAAAA, 1'b0, 1'b0, 32'h0));  // evicts PB
        end

        do_reset();
        // resolve_valid while IDLE must not train or pulse
        i_resolve_valid = 1'b1;
        i_resolve_data  = 32'h1234;
        @(negedge clk);
        i_resolve_valid = 1'b0;
        chk("idle_resolve_pulse", {31'd0, o_done | o_recover | o_vp_lock}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 9) sp_before = exp_sp;
            txn(vecs[i].pc, vecs[i].val, vecs[i].early, vecs[i].exp_pv, vecs[i].exp_pd,
                i % 2, (i / 2) % 3, $sformatf("vec%0d", i));
        end
        chk("alias_no_pred", 32'(exp_sp), 32'(sp_before));
        chk_stats("vec");

        // Start while SPEC is ignored; then reset while in RECOVER.
        do_reset();
        for (int i = 0; i < 3; i++) txn(PA, 32'h1234, 1'b0, 1'b0, 32'h0, 0, 0, "h_train");
        i_start    = 1'b1;
        i_start_pc = PA;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        chk("h_spec_pv", {31'd0, o_pred_valid}, 32'd1);
        chk("h_spec_pd", o_pred_data, 32'h1234);
        i_start    = 1'b1;
        i_start_pc = PC;
        chk("h_spec_ready", {31'd0, o_start_ready}, 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        chk("h_spec_hold", {31'd0, o_pred_valid}, 32'd1);
        chk("h_spec_lpc", o_last_pc, PA);
        i_resolve_valid = 1'b1;
        i_resolve_data  = 32'h9999;
        @(negedge clk);
        i_resolve_valid = 1'b0;
        chk("h_rec_pulse", {31'd0, o_recover}, 32'd1);
        @(negedge clk);
        chk("h_rec_lock", {31'd0, o_vp_lock}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("h_midrst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(PA, 32'h1234, 1'b0, 1'b0, 32'h0, 0, 0, "h_cleared");
        chk_stats("h");

        // Randomized transactions against the model.
        do_reset();
        pcs[0] = PA; pcs[1] = PB; pcs[2] = PC; pcs[3] = 32'h0123_4568;
        for (int t = 0; t < 150; t++) begin
            pc = pcs[$urandom_range(3)];
            if (model_hit(pc) && $urandom_range(3) != 0) val = m_data[midx(pc)];
            else if ($urandom_range(1) == 1) val = 32'h1234;
            else val = $urandom;
            pv = model_hit(pc) && (m_conf[midx(pc)] >= 2);
            txn(pc, val, ($urandom_range(7) == 0), pv, pv ? m_data[midx(pc)] : 32'h0,
                $urandom_range(2), $urandom_range(2), $sformatf("rnd%0d", t));
        end
        chk_stats("rnd");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
